// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin one-hot arbiter.
// Purpose: arbiter state encoding and default sizing. Latency: n/a. Backpressure: n/a.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N_DEFAULT       = 8;
    localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Purpose: find the first set request at or after the priority pointer, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the result is only consumed when the arbiter decides to (re)grant.
module rr_priority_pick
    import arb_pkg::*;
#(
    parameter int N    = ARB_N_DEFAULT,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    pick_onehot,
    output logic [IDXW-1:0] pick_idx,
    output logic            any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic           found;
    int             off;
    int             sum;

    assign dbl = {req, req};
    assign rot = dbl >> ptr;
    assign any = |req;

    always_comb begin
        found       = 1'b0;
        off         = 0;
        pick_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        // Rotated offset back to an absolute index; ptr < N so one subtraction wraps it.
        sum = int'(ptr) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        pick_idx = any ? IDXW'(sum) : '0;
        if (any) begin
            pick_onehot[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Purpose: round-robin arbiter giving a registered one-hot mux select; optional watchdog via RR_ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after req sampled high; ack re-arbitrates in the same edge (no bubble).
// Backpressure: a grant is held until ack, reset, or (with RR_ARB_TIMEOUT_EN) the watchdog forces release.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N       = ARB_N_DEFAULT,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int IDXW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic            timeout
);

    if (N < 2 || TIMEOUT < 1) begin : g_param_check
        $error("rr_onehot_arbiter: requires N >= 2 and TIMEOUT >= 1");
    end

    arb_state_t      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDXW-1:0] grant_idx_q, grant_idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            vld_q, vld_d;
    logic            to_q, to_d;

    logic [IDXW-1:0] ptr_adv;
    logic [IDXW-1:0] pick_ptr;
    logic [N-1:0]    pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            any;
    logic            rel;
    logic            forced;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;

    // A same-cycle ack wins over the watchdog, so forced release needs ack low.
    assign forced = (state_q == ARB_GRANT) && !ack && (cnt_q == CNTW'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE || rel) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign forced = 1'b0;
`endif

    assign rel      = (state_q == ARB_GRANT) && (ack || forced);
    assign ptr_adv  = (grant_idx_q == IDXW'(N - 1)) ? '0 : grant_idx_q + IDXW'(1);
    // On release the freshly advanced pointer is used so the pick happens in the same edge.
    assign pick_ptr = rel ? ptr_adv : ptr_q;

    rr_priority_pick #(
        .N    (N),
        .IDXW (IDXW)
    ) u_pick (
        .req         (req),
        .ptr         (pick_ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .any         (any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        vld_d       = vld_q;
        ptr_d       = ptr_q;
        to_d        = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    state_d     = ARB_GRANT;
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    vld_d       = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (rel) begin
                    ptr_d       = ptr_adv;
                    to_d        = forced;
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    vld_d       = any;
                    state_d     = any ? ARB_GRANT : ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            vld_q       <= 1'b0;
            ptr_q       <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            vld_q       <= vld_d;
            ptr_q       <= ptr_d;
            to_q        <= to_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = vld_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Randomized and directed bench for rr_onehot_arbiter against a queue-free round-robin reference.
module tb_rr_onehot_arbiter;

    localparam int N      = 8;
    localparam int TO_LIM = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [2:0]   grant_idx;
    logic         timeout;

    int tests  = 0;
    int failed = 0;

    // Reference state: granted index (-1 when idle), pointer, watchdog count, timeout pulse.
    int m_gidx = -1;
    int m_ptr  = 0;
    int m_cnt  = 0;
    bit m_to   = 1'b0;

    rr_onehot_arbiter #(
        .N       (N),
        .TIMEOUT (TO_LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] one;
        one = 1;
        return (m_gidx < 0) ? '0 : (one << m_gidx);
    endfunction

    function automatic logic [2:0] exp_idx();
        return (m_gidx < 0) ? 3'd0 : 3'(m_gidx);
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic a, input logic rs);
        bit fr;
        if (rs) begin
            m_gidx = -1; m_ptr = 0; m_cnt = 0; m_to = 1'b0;
        end else if (m_gidx < 0) begin
            m_to = 1'b0; m_cnt = 0;
            if (r != 0) m_gidx = pick(r, m_ptr);
        end else begin
            fr = TO_EN && !a && (m_cnt == TO_LIM);
            if (a || fr) begin
                m_ptr  = (m_gidx + 1) % N;
                m_gidx = (r != 0) ? pick(r, m_ptr) : -1;
                m_cnt  = 0;
                m_to   = fr;
            end else begin
                m_cnt++;
                m_to = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the reference.
    task automatic cycle(input logic [N-1:0] r, input logic a, input logic rs);
        req = r; ack = a; reset = rs;
        @(posedge clk);
        model_step(r, a, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(8'hFF, 1'b1, 1'b1);
            if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0 || timeout !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold c%0d: grant=%h vld=%b idx=%0d to=%b, want 00/0/0/0", c, grant, grant_valid, grant_idx, timeout);
            end
            tests++;
        end
        cycle(8'hFF, 1'b0, 1'b0);
        if (grant !== 8'h01 || grant_valid !== 1'b1 || grant_idx !== 3'd0) begin
            failed++;
            $display("FAIL reset_release: grant=%h vld=%b idx=%0d, want 01/1/0", grant, grant_valid, grant_idx);
        end
        tests++;
    endtask

    task automatic test_rotation();
        int hits[N];
        logic [N-1:0] want;
        for (int i = 0; i < N; i++) hits[i] = 0;
        for (int c = 0; c < 2 * N; c++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            want = 8'h01 << ((c + 1) % N);
            if (grant !== want || grant !== exp_grant() || grant_valid !== 1'b1) begin
                failed++;
                $display("FAIL rotation c%0d: grant=%h vld=%b, want %h/1", c, grant, grant_valid, want);
            end
            tests++;
            for (int i = 0; i < N; i++) if (grant[i]) hits[i]++;
        end
        for (int i = 0; i < N; i++) begin
            if (hits[i] != 2) begin
                failed++;
                $display("FAIL fairness req%0d: granted %0d times, want 2", i, hits[i]);
            end
            tests++;
        end
    endtask

    task automatic test_wrap();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h04, 1'b0, 1'b0);
        cycle(8'b0010_0010, 1'b1, 1'b0);
        if (grant !== 8'h20 || grant_idx !== 3'd5 || grant !== exp_grant()) begin
            failed++;
            $display("FAIL wrap_ptr3: grant=%h idx=%0d, want 20/5", grant, grant_idx);
        end
        tests++;
        cycle(8'b0010_0010, 1'b1, 1'b0);
        if (grant !== 8'h02 || grant_idx !== 3'd1 || grant !== exp_grant()) begin
            failed++;
            $display("FAIL wrap_around: grant=%h idx=%0d, want 02/1", grant, grant_idx);
        end
        tests++;
    endtask

    task automatic test_hold();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h04, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle(8'h40, 1'b0, 1'b0);
            if (grant !== 8'h04 || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
                failed++;
                $display("FAIL hold c%0d: grant=%h idx=%0d vld=%b, want 04/2/1", c, grant, grant_idx, grant_valid);
            end
            tests++;
        end
        cycle(8'h40, 1'b1, 1'b0);
        if (grant !== 8'h40 || grant_idx !== 3'd6 || grant !== exp_grant()) begin
            failed++;
            $display("FAIL hold_release: grant=%h idx=%0d, want 40/6", grant, grant_idx);
        end
        tests++;
    endtask

    task automatic test_reset_mid_grant();
        cycle(8'hFF, 1'b1, 1'b1);
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            failed++;
            $display("FAIL reset_mid: grant=%h vld=%b idx=%0d, want 00/0/0", grant, grant_valid, grant_idx);
        end
        tests++;
        cycle(8'h80, 1'b0, 1'b0);
        if (grant !== 8'h80 || grant_idx !== 3'd7) begin
            failed++;
            $display("FAIL reset_mid_regrant: grant=%h idx=%0d, want 80/7", grant, grant_idx);
        end
        tests++;
        // Pointer must have restarted at 0: serving 7 wraps it back to 0, so req 0 wins.
        cycle(8'hFF, 1'b1, 1'b0);
        if (grant !== 8'h01 || grant !== exp_grant()) begin
            failed++;
            $display("FAIL reset_mid_ptr: grant=%h, want 01", grant);
        end
        tests++;
    endtask

    task automatic test_timeout();
        logic [N-1:0] wg;
        logic         wt;
        cycle(8'h00, 1'b0, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            cycle(8'h03, 1'b0, 1'b0);
            wg = 8'h01; wt = 1'b0;
            if (TO_EN && c >= 6) wg = 8'h02;
            if (TO_EN && c == 6) wt = 1'b1;
            if (grant !== wg || timeout !== wt || grant !== exp_grant() || timeout !== m_to) begin
                failed++;
                $display("FAIL timeout c%0d: grant=%h to=%b, want %h/%b", c, grant, timeout, wg, wt);
            end
            tests++;
        end
        // Ack on the exact cycle the watchdog would fire is a normal ack.
        cycle(8'h00, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            cycle(8'h03, (c == 6), 1'b0);
            wg = (c == 6) ? 8'h02 : 8'h01;
            if (grant !== wg || timeout !== 1'b0) begin
                failed++;
                $display("FAIL timeout_ack c%0d: grant=%h to=%b, want %h/0", c, grant, timeout, wg);
            end
            tests++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         a;
        logic         rs;
        for (int c = 0; c < 600; c++) begin
            r  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            a  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 63) == 0);
            cycle(r, a, rs);
            if (grant !== exp_grant() || grant_valid !== (m_gidx >= 0) || grant_idx !== exp_idx()
                || timeout !== m_to || $countones(grant) > 1) begin
                failed++;
                $display("FAIL random c%0d: grant=%h vld=%b idx=%0d to=%b, want %h/%b/%0d/%b",
                         c, grant, grant_valid, grant_idx, timeout, exp_grant(), (m_gidx >= 0), exp_idx(), m_to);
            end
            tests++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_hold();
        test_reset_mid_grant();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that produces the registered one-hot select consumed by the 8-way one-hot mux in the frisc datapath.
- Used for shared-resource access, e.g. a writeback port or a memory port.
- Requesters raise req bits; the arbiter issues a stable one-hot grant and holds it until the downstream consumer acknowledges completion.
- Fairness comes from a rotating priority pointer.

Parameters:
N, 8, number of requesters; N >= 2; need not be a power of two
IDXW, $clog2(N), width of grant_idx and the priority pointer
TIMEOUT, 16, watchdog limit in cycles (used only with the optional feature); >= 1

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request bits, one per requester, level-sensitive
ack  input  1  downstream completed the granted transaction; sampled only in GRANT
grant  output  N  registered one-hot grant; all zero when idle; drives the mux sel
grant_valid  output  1  high exactly when grant is non-zero
grant_idx  output  IDXW  binary index of the granted requester; 0 when idle
timeout  output  1  one-cycle pulse on forced release; tied 0 without the macro

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: on any edge with reset=1:
  - state=IDLE, ptr=0, grant=0, grant_valid=0, grant_idx=0, timeout=0.
  - Reset overrides ack and req in the same cycle.
  - Reset mid-GRANT drops the grant at that edge; no pointer update.
- States: IDLE, GRANT.
- Pick function: lowest index i in the order ptr, ptr+1, ..., ptr+N-1 (mod N) with req[i]=1.
- IDLE:
  - If |req, the next edge sets grant to the one-hot of pick, grant_idx=pick, and state=GRANT.
  - Grant latency is 1 cycle from req being sampled high.
  - If req=0, stay in IDLE.
  - ack is ignored.
- GRANT:
  - grant and grant_idx are held stable regardless of req changes.
  - The grant is never revoked except by ack, reset, or the optional timeout.
- ack=1 in GRANT:
  - ptr <= (grant_idx+1) mod N. Wrap: idx N-1 -> ptr 0.
  - Back-to-back: in the same edge, re-arbitrate using the current-cycle req with the updated pointer.
    - If any req, go directly to GRANT with the new pick (no bubble).
    - Otherwise go to IDLE with grant=0.
  - The just-served requester has the lowest priority but wins if it is the sole requester.
- ack=0 in GRANT: hold.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches grant.
  - ptr changes only on ack (or timeout).
- Fairness: with all N requesting continuously and ack every cycle, each requester is granted exactly once per N grants.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter resets to 0 on entering GRANT and increments each GRANT cycle with ack=0.
  - When the counter reaches TIMEOUT, the next edge forces release: pointer advances as if acked, timeout=1 for one cycle, and re-arbitration runs.
  - The timed-out requester is not excluded beyond normal rotation.
  - ack arriving in the same cycle the counter reaches TIMEOUT counts as a normal ack; timeout stays 0.
- Without the macro: no counter is instantiated, timeout is constant 0, and a grant may be held indefinitely.

Decomposition:
- Shared package arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
  - Constant ARB_N_DEFAULT=8.
  - Constant ARB_TIMEOUT_DEFAULT=16.
- One natural sub-module, rr_priority_pick: purely combinational.
  - Inputs: req[N], ptr[IDXW].
  - Outputs: pick_onehot[N], pick_idx[IDXW], any.
  - Implemented as a double-width rotate and find-first.
  - Instantiated once in the arbiter.

Test Plan:
- Reset with req=8'hFF asserted throughout -> grant=0, grant_valid=0 while reset=1. First edge after release: grant=8'h01, grant_idx=0.
- req=8'hFF held, ack=1 every cycle -> grant sequence 01,02,04,...,80,01 with no idle cycles; each bit granted once per 8 grants.
- ptr=3 (after serving idx 2), req=8'b0010_0010 -> grant=8'h20 (idx 5). After ack with req unchanged -> grant=8'h02 (idx 1, wrap).
- Grant 8'h04 held while req[2] drops and req[6] rises, ack=0 for 5 cycles -> grant stays 8'h04. ack=1 -> next grant 8'h40.
- Reset asserted mid-GRANT with ack=1 in the same cycle -> grant=0, ptr=0 at that edge. With req=8'h80 after release -> grant=8'h80.
- With RR_ARB_TIMEOUT_EN, TIMEOUT=4, req=8'h03, ack=0 -> grant=8'h01 for 5 cycles, then one-cycle timeout=1 and grant=8'h02. Without the macro, grant=8'h01 persists and timeout stays 0.
